// File: rtl/fp_mul_host_if.sv
// fp_mul_host_if
//   Groups the signals of fp_mul_host that are not clock or reset.
//   Request side (system requester <-> host):
//     start        request; taken on a rising edge where busy=0
//     op_a, op_b   64-bit operands, sampled with the accepted start
//     busy         host is in a transaction (including the idle gap)
//     result_valid one-cycle strobe qualifying result/timeout_err
//     result       assembled product, held until the next strobe
//     timeout_err  1 = the slave never raised READY
//   Link side (host <-> FP_MUL):
//     ENABLE       DATA_IN carries an operand byte this cycle
//     DATA_IN      operand byte
//     DATA_OUT     product byte from FP_MUL
//     READY        rising edge marks product byte 0 on DATA_OUT
//   The modport named master is the host's view; slave is the view of
//   whatever sits around the host (requester plus FP_MUL).
interface fp_mul_host_if;
    logic        start;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        busy;
    logic        result_valid;
    logic [63:0] result;
    logic        timeout_err;
    logic        ENABLE;
    logic [7:0]  DATA_IN;
    logic [7:0]  DATA_OUT;
    logic        READY;

    modport master (
        input  start, op_a, op_b, DATA_OUT, READY,
        output busy, result_valid, result, timeout_err, ENABLE, DATA_IN
    );

    modport slave (
        output start, op_a, op_b, DATA_OUT, READY,
        input  busy, result_valid, result, timeout_err, ENABLE, DATA_IN
    );
endinterface

// File: rtl/fp_mul_host.sv
// fp_mul_host
//   Byte-serial initiator for the FP_MUL link. Takes two 64-bit operands in
//   parallel, streams them LSB byte first over ENABLE/DATA_IN (A then B),
//   waits for a rising edge on READY, collects eight product bytes from
//   DATA_OUT and presents the product as a one-cycle parallel strobe.
//   Operands are passed through untouched; no floating-point interpretation.
// Ports:
//   CLK        clock, all logic on the rising edge
//   RESET      synchronous, active-high reset
//   bus        fp_mul_host_if.master (request side and FP_MUL link)
//   state_dbg  current FSM state encoding, for observation only
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed in WAIT before giving up (>= 1)
//   GAP_CYCLES      idle cycles after each transaction before the next start
//
// Handshake semantics: a request is taken on a rising edge where start=1 and
// busy=0 (busy rises on the following cycle and stays high through the gap;
// start while busy is dropped, never queued). result_valid is a single-cycle
// strobe with no back-pressure. On the link, ENABLE=1 qualifies one DATA_IN
// byte per cycle for 16 consecutive cycles; the first cycle where READY is
// high after being low (while waiting) carries product byte 0, and bytes
// 1..7 follow on consecutive cycles regardless of READY.
module fp_mul_host #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int GAP_CYCLES     = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    fp_mul_host_if.master bus,
    output logic [2:0]    state_dbg
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND_A = 3'd1,
        ST_SEND_B = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RECV   = 3'd4,
        ST_DONE   = 3'd5,
        ST_GAP    = 3'd6
    } state_t;

    state_t        state_q, state_n;
    logic [2:0]    idx_q, idx_n;
    logic [TW-1:0] tcnt_q, tcnt_n;
    logic [GW-1:0] gcnt_q, gcnt_n;
    logic [63:0]   a_q, a_n;
    logic [63:0]   b_q, b_n;
    logic [63:0]   rx_q, rx_n;
    logic [63:0]   result_q, result_n;
    logic          result_valid_q, result_valid_n;
    logic          timeout_err_q, timeout_err_n;
    logic          enable_q, enable_n;
    logic [7:0]    data_in_q, data_in_n;
    logic          busy_q, busy_n;
    logic          ready_d_q;
    logic          ready_rise;

    function automatic logic [7:0] sel_byte(input logic [63:0] w, input logic [2:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

    // READY already high on WAIT entry leaves ready_d high, so it is not
    // mistaken for the start of a result transfer.
    assign ready_rise = bus.READY & ~ready_d_q;

    always_comb begin
        state_n        = state_q;
        idx_n          = idx_q;
        tcnt_n         = tcnt_q;
        gcnt_n         = gcnt_q;
        a_n            = a_q;
        b_n            = b_q;
        rx_n           = rx_q;
        result_n       = result_q;
        timeout_err_n  = timeout_err_q;
        busy_n         = busy_q;
        result_valid_n = 1'b0;
        enable_n       = 1'b0;
        data_in_n      = 8'd0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_n       = bus.op_a;
                    b_n       = bus.op_b;
                    idx_n     = 3'd0;
                    enable_n  = 1'b1;
                    data_in_n = bus.op_a[7:0];
                    busy_n    = 1'b1;
                    state_n   = ST_SEND_A;
                end
            end
            // In SEND_A/SEND_B, idx is the byte currently on DATA_IN; the
            // next byte is loaded so that DATA_IN stays registered.
            ST_SEND_A: begin
                enable_n = 1'b1;
                if (idx_q == 3'd7) begin
                    idx_n     = 3'd0;
                    data_in_n = b_q[7:0];
                    state_n   = ST_SEND_B;
                end else begin
                    idx_n     = idx_q + 3'd1;
                    data_in_n = sel_byte(a_q, idx_q + 3'd1);
                end
            end
            ST_SEND_B: begin
                if (idx_q == 3'd7) begin
                    tcnt_n  = '0;
                    state_n = ST_WAIT;
                end else begin
                    enable_n  = 1'b1;
                    idx_n     = idx_q + 3'd1;
                    data_in_n = sel_byte(b_q, idx_q + 3'd1);
                end
            end
            // Capture is checked before the limit so that an edge arriving
            // on the last allowed cycle still wins.
            ST_WAIT: begin
                if (ready_rise) begin
                    rx_n[7:0] = bus.DATA_OUT;
                    idx_n     = 3'd1;
                    state_n   = ST_RECV;
                end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    result_n       = '0;
                    timeout_err_n  = 1'b1;
                    result_valid_n = 1'b1;
                    state_n        = ST_DONE;
                end else begin
                    tcnt_n = tcnt_q + 1'b1;
                end
            end
            // Bytes are gathered in rx and copied to result only at the
            // strobe, so result never shows a half-assembled product.
            ST_RECV: begin
                rx_n[{idx_q, 3'b000} +: 8] = bus.DATA_OUT;
                if (idx_q == 3'd7) begin
                    result_n       = rx_n;
                    timeout_err_n  = 1'b0;
                    result_valid_n = 1'b1;
                    state_n        = ST_DONE;
                end else begin
                    idx_n = idx_q + 3'd1;
                end
            end
            // result_valid is high during DONE (it was registered on entry).
            ST_DONE: begin
                gcnt_n = '0;
                if (GAP_CYCLES == 0) begin
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gcnt_q == GW'(GAP_CYCLES - 1)) begin
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                end else begin
                    gcnt_n = gcnt_q + 1'b1;
                end
            end
            default: begin
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            tcnt_q         <= '0;
            gcnt_q         <= '0;
            a_q            <= '0;
            b_q            <= '0;
            rx_q           <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            enable_q       <= 1'b0;
            data_in_q      <= '0;
            busy_q         <= 1'b0;
            ready_d_q      <= 1'b0;
        end else begin
            state_q        <= state_n;
            idx_q          <= idx_n;
            tcnt_q         <= tcnt_n;
            gcnt_q         <= gcnt_n;
            a_q            <= a_n;
            b_q            <= b_n;
            rx_q           <= rx_n;
            result_q       <= result_n;
            result_valid_q <= result_valid_n;
            timeout_err_q  <= timeout_err_n;
            enable_q       <= enable_n;
            data_in_q      <= data_in_n;
            busy_q         <= busy_n;
            ready_d_q      <= bus.READY;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result       = result_q;
    assign bus.timeout_err  = timeout_err_q;
    assign bus.ENABLE       = enable_q;
    assign bus.DATA_IN      = data_in_q;
    assign state_dbg        = state_q;
endmodule
